// File: rtl/crossbar_rr_pkg.sv
// crossbar_rr_pkg
// Shared definitions for the round-robin crossbar:
//   idx_w()   - port-index width for an N-port crossbar (ceil(log2(n)), at least 1)
//   PTR_RST   - arbiter pointer value after reset
//   DATA_RST  - bit value replicated into held data/source fields after reset
package crossbar_rr_pkg;

    function automatic int idx_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    localparam int   PTR_RST  = 0;
    localparam logic DATA_RST = 1'b0;

endpackage

// File: rtl/rr_arb.sv
// rr_arb
// N-request round-robin arbiter. The grant goes to the first requester at or
// after the pointer, searching upward and wrapping. The pointer moves to one
// past the winner only when the owner can take the word (en) and a grant exists.
// Ports:
//   clk, rst  - clock, async active-high reset
//   req       - request vector, one bit per input
//   en        - consumer can load this cycle
//   gnt       - one-hot grant (combinational, independent of en)
//   gnt_idx   - binary index of the granted input
//   any       - at least one request present
module rr_arb
    import crossbar_rr_pkg::*;
#(
    parameter int N  = 16,
    parameter int AW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [AW-1:0] gnt_idx,
    output logic          any
);

    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_nxt;
    logic [AW:0]   sum;
    logic [AW-1:0] idx;

    // Walk the N candidates starting at ptr; sum is one bit wider so the
    // wrap test against N is exact for non-power-of-two N.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (AW+1)'(k);
            if (sum >= (AW+1)'(N)) sum = sum - (AW+1)'(N);
            idx = sum[AW-1:0];
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

    always_comb begin
        ptr_nxt = gnt_idx + AW'(1);
        if (gnt_idx == AW'(N-1)) ptr_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= AW'(PTR_RST);
        else if (en && any)
            ptr <= ptr_nxt;
    end

endmodule

// File: rtl/crossbar_rr.sv
// crossbar_rr
// N x N crossbar with a one-entry register and a round-robin arbiter per
// output. Words to an out-of-range destination are accepted, dropped, and
// latch the sticky err flag.
// Ports:
//   clk, rst   - clock, async active-high reset
//   in_valid   - per-input valid                     [N]
//   in_dest    - per-input destination index          [N*AW]
//   in_data    - per-input data                       [N*DW]
//   in_ready   - per-input accept, combinational      [N]
//   out_valid  - per-output held word valid, reg      [N]
//   out_src    - per-output source index, reg         [N*AW]
//   out_data   - per-output data, reg                 [N*DW]
//   out_ready  - per-output sink accept               [N]
//   err        - sticky illegal-destination flag
module crossbar_rr
    import crossbar_rr_pkg::*;
#(
    parameter int DW = 64,
    parameter int N  = 16,
    parameter int AW = idx_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    input  logic [N*AW-1:0] in_dest,
    input  logic [N*DW-1:0] in_data,
    output logic [N-1:0]    in_ready,
    output logic [N-1:0]    out_valid,
    output logic [N*AW-1:0] out_src,
    output logic [N*DW-1:0] out_data,
    input  logic [N-1:0]    out_ready,
    output logic            err
);

    logic [N-1:0][AW-1:0] dest_a;
    logic [N-1:0][DW-1:0] data_a;
    logic [N-1:0][N-1:0]  req_m;   // [output][input]
    logic [N-1:0][N-1:0]  gnt_m;   // [output][input]
    logic [N-1:0][AW-1:0] gidx;
    logic [N-1:0]         gany;
    logic [N-1:0]         can_load;
    logic [N-1:0]         illegal;
    logic [N-1:0]         rdy;

    logic [N-1:0]         vld_q;
    logic [N-1:0][AW-1:0] src_q;
    logic [N-1:0][DW-1:0] data_q;
    logic                 err_q;

    assign dest_a = in_dest;
    assign data_a = in_data;

    // Destination decode; an index >= N matches no output and is flagged.
    always_comb begin
        req_m   = '0;
        illegal = '0;
        for (int i = 0; i < N; i++) begin
            illegal[i] = in_valid[i] && (int'(dest_a[i]) >= N);
            for (int j = 0; j < N; j++)
                req_m[j][i] = in_valid[i] && (dest_a[i] == AW'(j));
        end
    end

    // An output register may load when empty or draining this cycle.
    assign can_load = ~vld_q | out_ready;

    for (genvar j = 0; j < N; j++) begin : g_arb
        rr_arb #(.N(N), .AW(AW)) u_arb (
            .clk     (clk),
            .rst     (rst),
            .req     (req_m[j]),
            .en      (can_load[j]),
            .gnt     (gnt_m[j]),
            .gnt_idx (gidx[j]),
            .any     (gany[j])
        );
    end

    // An input is accepted if any loadable output granted it, or if its word
    // is being discarded. Nothing is accepted during reset.
    always_comb begin
        rdy = '0;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                rdy[i] = illegal[i];
                for (int j = 0; j < N; j++)
                    rdy[i] = rdy[i] | (gnt_m[j][i] & can_load[j]);
            end
        end
    end
    assign in_ready = rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            src_q  <= {(N*AW){DATA_RST}};
            data_q <= {(N*DW){DATA_RST}};
        end else begin
            for (int j = 0; j < N; j++) begin
                if (can_load[j]) begin
                    vld_q[j] <= gany[j];
                    if (gany[j]) begin
                        data_q[j] <= data_a[gidx[j]];
                        src_q[j]  <= gidx[j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (|illegal)
            err_q <= 1'b1;
    end

    assign out_valid = vld_q;
    assign out_src   = src_q;
    assign out_data  = data_q;
    assign err       = err_q;

endmodule
